mac_accum_stage: RTL and testbench

//  Downstream consumer of the 4x4 signed pipelined multiplier. Accepts its 8-bit signed products
//  via a valid/ready handshake and accumulates them into a dot product, with optional saturation.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_accum_stage_if.sv | 28 ++
 rtl/mac_accum_stage_sat_add.sv | 30 +++
 rtl/mac_accum_stage.sv | 119 +++++++++++
 tb/tb_mac_accum_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulate stage.
package mac_pkg;

   localparam int PROD_W_DEF = 8;
   localparam int ACC_W_DEF  = 16;
   localparam int CNT_W_DEF  = 8;

   localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
   localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

   // ST_FIRST: the next accepted beat starts a new vector
   typedef enum logic {ST_FIRST, ST_RUN} state_e;

endpackage

// File: rtl/mac_accum_stage_if.sv
// Product-in / result-out handshake bundle for the MAC accumulate stage.
interface mac_accum_stage_if
   import mac_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [PROD_W-1:0] in_prod;
   logic                     in_last;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]         out_len;
   logic                     out_ovf;

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_len, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_len, out_ovf
   );
endinterface

// File: rtl/mac_accum_stage_sat_add.sv
// Adds a sign-extended product to the running sum; flags overflow and
// optionally clamps to the representable range.
module sat_add
   import mac_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter bit SAT_EN = 1'b1
) (
   input  logic signed [ACC_W-1:0]  a,
   input  logic signed [PROD_W-1:0] b,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     ovf
);
   localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] wide;

   always_comb begin
      // One guard bit: the top two bits disagree exactly when the true sum
      // does not fit in ACC_W bits.
      wide = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
      ovf  = wide[ACC_W] ^ wide[ACC_W-1];
      sum  = wide[ACC_W-1:0];
      if (SAT_EN && ovf) begin
         sum = wide[ACC_W] ? MIN_V : MAX_V;
      end
   end
endmodule

// File: rtl/mac_accum_stage.sv
// Accumulates signed products into a dot product per in_last-terminated
// vector and holds the result in a one-entry output register.
module mac_accum_stage
   import mac_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter bit SAT_EN = 1'b1
) (
   input logic               clk,
   input logic               rst,
   mac_accum_stage_if.slave  bus
);
   state_e                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_run_q, ovf_run_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0]        out_len_q, out_len_d;
   logic                    out_ovf_q, out_ovf_d;

   logic                    in_ready;
   logic                    beat;
   logic                    first;
   logic signed [ACC_W-1:0] base;
   logic signed [ACC_W-1:0] sum;
   logic                    add_ovf;
   logic [CNT_W-1:0]        base_cnt;
   logic [CNT_W-1:0]        cnt_inc;
   logic                    ovf_next;

   // The output register doubles as a pipeline slot: a consumed result
   // frees it in the same cycle.
   assign in_ready = ~out_valid_q | bus.out_ready;
   assign beat     = bus.in_valid & in_ready;
   assign first    = (state_q == ST_FIRST);
   assign base     = first ? '0 : acc_q;
   assign base_cnt = first ? '0 : cnt_q;
   assign cnt_inc  = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
   assign ovf_next = (~first & ovf_run_q) | add_ovf;

   sat_add #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W),
      .SAT_EN (SAT_EN)
   ) u_sat_add (
      .a   (base),
      .b   (bus.in_prod),
      .sum (sum),
      .ovf (add_ovf)
   );

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_run_d   = ovf_run_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_len_d   = out_len_q;
      out_ovf_d   = out_ovf_q;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (beat) begin
         if (bus.in_last) begin
            out_sum_d   = sum;
            out_len_d   = cnt_inc;
            out_ovf_d   = ovf_next;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_run_d   = 1'b0;
            state_d     = ST_FIRST;
         end else begin
            acc_d       = sum;
            cnt_d       = cnt_inc;
            ovf_run_d   = ovf_next;
            state_d     = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_FIRST;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_run_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_len_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_run_q   <= ovf_run_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_len_q   <= out_len_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_len   = out_len_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_mac_accum_stage.sv
// Directed bench for mac_accum_stage: a 16-bit saturating instance plus two
// 8-bit instances (saturating and wrapping, 2-bit beat counter).
module tb_mac_accum_stage;
   import mac_pkg::*;

   typedef struct {
      logic signed [31:0] sum;
      logic signed [31:0] len;
      logic signed [31:0] ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mac_accum_stage_if #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) b16 ();
   mac_accum_stage_if #(.PROD_W(8), .ACC_W(8),  .CNT_W(2)) b8s ();
   mac_accum_stage_if #(.PROD_W(8), .ACC_W(8),  .CNT_W(2)) b8w ();

   mac_accum_stage #(.PROD_W(8), .ACC_W(16), .CNT_W(8), .SAT_EN(1'b1))
      dut16 (.clk(clk), .rst(rst), .bus(b16));
   mac_accum_stage #(.PROD_W(8), .ACC_W(8), .CNT_W(2), .SAT_EN(1'b1))
      dut8s (.clk(clk), .rst(rst), .bus(b8s));
   mac_accum_stage #(.PROD_W(8), .ACC_W(8), .CNT_W(2), .SAT_EN(1'b0))
      dut8w (.clk(clk), .rst(rst), .bus(b8w));

   res_t q16[$];
   res_t q8s[$];
   res_t q8w[$];

   int n_cmp = 0;
   int n_err = 0;
   bit acc16;
   bit acc8;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input int which, input int sum, input int len, input int ovf);
      res_t r;
      r.sum = sum;
      r.len = len;
      r.ovf = ovf;
      case (which)
         0:       q16.push_back(r);
         1:       q8s.push_back(r);
         default: q8w.push_back(r);
      endcase
   endtask

   task automatic pop_check(input int which, input logic signed [31:0] sum,
                            input logic signed [31:0] len, input logic ovf);
      res_t e;
      int   sz;
      sz = (which == 0) ? q16.size() : (which == 1) ? q8s.size() : q8w.size();
      chk($sformatf("res%0d_expected", which), (sz > 0) ? 1 : 0, 1);
      if (sz > 0) begin
         case (which)
            0:       e = q16.pop_front();
            1:       e = q8s.pop_front();
            default: e = q8w.pop_front();
         endcase
         chk($sformatf("res%0d_sum", which), sum, e.sum);
         chk($sformatf("res%0d_len", which), len, e.len);
         chk($sformatf("res%0d_ovf", which), {31'd0, ovf}, e.ovf);
      end
   endtask

   // Inputs are driven just after posedge; the negedge sees settled values
   // for both beat acceptance and result consumption.
   task automatic cycle();
      @(negedge clk);
      acc16 = b16.in_valid & b16.in_ready;
      acc8  = b8s.in_valid & b8s.in_ready & b8w.in_valid & b8w.in_ready;
      if (b16.out_valid && b16.out_ready)
         pop_check(0, b16.out_sum, {24'd0, b16.out_len}, b16.out_ovf);
      if (b8s.out_valid && b8s.out_ready)
         pop_check(1, b8s.out_sum, {30'd0, b8s.out_len}, b8s.out_ovf);
      if (b8w.out_valid && b8w.out_ready)
         pop_check(2, b8w.out_sum, {30'd0, b8w.out_len}, b8w.out_ovf);
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit sel8, input int p, input bit last);
      bit got = 1'b0;
      if (sel8) begin
         b8s.in_valid = 1'b1; b8s.in_prod = p[7:0]; b8s.in_last = last;
         b8w.in_valid = 1'b1; b8w.in_prod = p[7:0]; b8w.in_last = last;
      end else begin
         b16.in_valid = 1'b1; b16.in_prod = p[7:0]; b16.in_last = last;
      end
      for (int i = 0; i < 40 && !got; i++) begin
         cycle();
         got = sel8 ? acc8 : acc16;
      end
      chk("beat_accepted", {31'd0, got}, 1);
      b16.in_valid = 1'b0; b16.in_last = 1'b0;
      b8s.in_valid = 1'b0; b8s.in_last = 1'b0;
      b8w.in_valid = 1'b0; b8w.in_last = 1'b0;
   endtask

   initial begin
      b16.in_valid = 1'b1; b16.in_prod = 8'sd7; b16.in_last = 1'b0; b16.out_ready = 1'b1;
      b8s.in_valid = 1'b0; b8s.in_prod = '0;    b8s.in_last = 1'b0; b8s.out_ready = 1'b1;
      b8w.in_valid = 1'b0; b8w.in_prod = '0;    b8w.in_last = 1'b0; b8w.out_ready = 1'b1;

      // 1: reset held two clocks with in_valid asserted
      cycle();
      cycle();
      rst = 1'b0;
      b16.in_valid = 1'b0;
      chk("rst_out_valid", {31'd0, b16.out_valid}, 0);
      chk("rst_out_sum", b16.out_sum, 0);
      chk("rst_out_len", {24'd0, b16.out_len}, 0);
      chk("rst_out_ovf", {31'd0, b16.out_ovf}, 0);
      chk("rst_in_ready", {31'd0, b16.in_ready}, 1);
      chk("rst_out_valid_8", {31'd0, b8s.out_valid}, 0);

      // 2: four-beat vector, one-clock latency to out_valid
      beat(0, 3, 0);
      beat(0, -5, 0);
      beat(0, 7, 0);
      chk("t2_no_early_valid", {31'd0, b16.out_valid}, 0);
      push(0, 54, 4, 0);
      beat(0, 49, 1);
      chk("t2_latency", {31'd0, b16.out_valid}, 1);
      cycle();
      chk("t2_valid_drop", {31'd0, b16.out_valid}, 0);

      // 3: 8-bit saturate vs wrap, sticky overflow clearing, count saturation
      push(1, 127, 3, 1);
      push(2, -97, 3, 1);
      beat(1, 100, 0);
      beat(1, 49, 0);
      beat(1, 10, 1);
      chk("t3_valid", {31'd0, b8s.out_valid}, 1);
      push(1, -1, 1, 0);
      push(2, -1, 1, 0);
      beat(1, -1, 1);
      push(1, -128, 2, 1);
      push(2, 107, 2, 1);
      beat(1, -100, 0);
      beat(1, -49, 1);
      push(1, 5, 3, 0);
      push(2, 5, 3, 0);
      for (int i = 0; i < 4; i++) beat(1, 1, 0);
      beat(1, 1, 1);
      cycle();

      // 4: backpressure holds the result and blocks the next vector
      push(0, 10, 1, 0);
      beat(0, 10, 1);
      b16.out_ready = 1'b0;
      b16.in_valid  = 1'b1; b16.in_prod = 8'sd2; b16.in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t4_no_accept", {31'd0, acc16}, 0);
         chk("t4_in_ready", {31'd0, b16.in_ready}, 0);
         chk("t4_out_valid", {31'd0, b16.out_valid}, 1);
         chk("t4_out_sum", b16.out_sum, 10);
      end
      b16.out_ready = 1'b1;
      beat(0, 2, 0);
      push(0, 4, 2, 0);
      beat(0, 2, 1);
      cycle();

      // 5: back-to-back single-beat vectors, no bubble
      push(0, -49, 1, 0);
      beat(0, -49, 1);
      chk("t5_valid0", {31'd0, b16.out_valid}, 1);
      push(0, 49, 1, 0);
      beat(0, 49, 1);
      chk("t5_valid1", {31'd0, b16.out_valid}, 1);
      push(0, 0, 1, 0);
      beat(0, 0, 1);
      chk("t5_valid2", {31'd0, b16.out_valid}, 1);
      cycle();

      // 6: reset mid-vector discards the partial sum
      beat(0, 10, 0);
      beat(0, 20, 0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      push(0, 5, 1, 0);
      beat(0, 5, 1);
      chk("t6_valid", {31'd0, b16.out_valid}, 1);
      cycle();
      cycle();

      chk("q16_drained", q16.size(), 0);
      chk("q8s_drained", q8s.size(), 0);
      chk("q8w_drained", q8w.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
